// File: rtl/dead_time_gen.sv
// dead_time_gen: multi-channel dead-time generator for an inverter bridge.
//
// Each channel turns one PWM command into complementary high-side / low-side
// gate drives. Every transition between the two on-states passes through a
// dead interval of max(DEAD,1) cycles, so both switches of a leg are never on
// together. EN=0 floats a leg (HS=LS=0) immediately.
//
// Optional feature macro: DT_FAULT_EN (adds a latched global fault shutdown).
//
// Parameters:
//   N_CH   number of bridge legs
//   CNT_W  width of DEAD and of the per-channel dead counters
// Ports:
//   CLK          system clock, rising edge
//   RST          synchronous active-high reset
//   EN[N_CH]     per-channel enable, 0 forces the leg off
//   PWM[N_CH]    per-channel command, 1 = high side, 0 = low side
//   DEAD[CNT_W]  dead time in cycles, sampled on entry to a dead interval
//   FAULT        (DT_FAULT_EN) fault input, forces all legs off and latches
//   FLT_CLR      (DT_FAULT_EN) clears the latch when FAULT=0
//   FLT_LATCHED  (DT_FAULT_EN) latched fault status
//   HS[N_CH]     registered high-side drive
//   LS[N_CH]     registered low-side drive
//   DT_ACTIVE    registered per-channel dead-interval flag
module dead_time_gen #(
  parameter int unsigned N_CH  = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_CH-1:0]  EN,
  input  logic [N_CH-1:0]  PWM,
  input  logic [CNT_W-1:0] DEAD,
`ifdef DT_FAULT_EN
  input  logic             FAULT,
  input  logic             FLT_CLR,
  output logic             FLT_LATCHED,
`endif
  output logic [N_CH-1:0]  HS,
  output logic [N_CH-1:0]  LS,
  output logic [N_CH-1:0]  DT_ACTIVE
);

  localparam logic [2:0] StOff = 3'd0;
  localparam logic [2:0] StLo  = 3'd1;
  localparam logic [2:0] StDtH = 3'd2;
  localparam logic [2:0] StHi  = 3'd3;
  localparam logic [2:0] StDtL = 3'd4;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       state_q [N_CH];
  logic [2:0]       state_d [N_CH];
  logic [CNT_W-1:0] cnt_q   [N_CH];
  logic [CNT_W-1:0] cnt_d   [N_CH];
  logic [N_CH-1:0]  hs_q, ls_q, dt_q;
  logic             force_off;

`ifdef DT_FAULT_EN
  logic flt_q;

  // FAULT wins over FLT_CLR; a clear only takes effect once FAULT is low.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flt_q <= 1'b0;
    end else if (FAULT) begin
      flt_q <= 1'b1;
    end else if (FLT_CLR) begin
      flt_q <= 1'b0;
    end
  end

  // Channels are held off on the clearing edge too; they restart from OFF on
  // the following edge through a full dead interval.
  assign force_off   = FAULT | flt_q;
  assign FLT_LATCHED = flt_q;
`else
  assign force_off = 1'b0;
`endif

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      if (force_off || !EN[i]) begin
        state_d[i] = StOff;
        cnt_d[i]   = '0;
      end else begin
        unique case (state_q[i])
          StOff: begin
            state_d[i] = PWM[i] ? StDtH : StDtL;
            cnt_d[i]   = DEAD;
          end
          StLo: begin
            if (PWM[i]) begin
              state_d[i] = StDtH;
              cnt_d[i]   = DEAD;
            end
          end
          StHi: begin
            if (!PWM[i]) begin
              state_d[i] = StDtL;
              cnt_d[i]   = DEAD;
            end
          end
          // Abort is checked before expiry: the opposite side never turned
          // on, so returning to the previous on-state needs no gap.
          StDtH: begin
            if (!PWM[i]) begin
              state_d[i] = StLo;
            end else if (cnt_q[i] <= CntOne) begin
              state_d[i] = StHi;
            end else begin
              cnt_d[i] = cnt_q[i] - CntOne;
            end
          end
          StDtL: begin
            if (PWM[i]) begin
              state_d[i] = StHi;
            end else if (cnt_q[i] <= CntOne) begin
              state_d[i] = StLo;
            end else begin
              cnt_d[i] = cnt_q[i] - CntOne;
            end
          end
          default: begin
            state_d[i] = StOff;
            cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  // Gate drives are decoded from the next state into flops so the pins come
  // straight off registers and track the state register cycle for cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= StOff;
        cnt_q[i]   <= '0;
      end
      hs_q <= '0;
      ls_q <= '0;
      dt_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
        hs_q[i]    <= (state_d[i] == StHi);
        ls_q[i]    <= (state_d[i] == StLo);
        dt_q[i]    <= (state_d[i] == StDtH) || (state_d[i] == StDtL);
      end
    end
  end

  assign HS        = hs_q;
  assign LS        = ls_q;
  assign DT_ACTIVE = dt_q;

endmodule

// File: tb/tb_dead_time_gen.sv
module tb_dead_time_gen;

  logic       CLK;
  logic       RST;
  logic [2:0] EN;
  logic [2:0] PWM;
  logic [7:0] DEAD;
  logic [2:0] HS, LS, DT_ACTIVE;
`ifdef DT_FAULT_EN
  logic       FAULT, FLT_CLR, FLT_LATCHED;
`endif

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  dead_time_gen #(.N_CH(3), .CNT_W(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .PWM        (PWM),
    .DEAD       (DEAD),
`ifdef DT_FAULT_EN
    .FAULT      (FAULT),
    .FLT_CLR    (FLT_CLR),
    .FLT_LATCHED(FLT_LATCHED),
`endif
    .HS         (HS),
    .LS         (LS),
    .DT_ACTIVE  (DT_ACTIVE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Shoot-through watch over the whole run.
  always @(negedge CLK) begin
    if (mon_en) begin
      total++;
      if ((HS & LS) !== 3'b000) begin
        bad++;
        $display("FAIL overlap t=%0t HS=%b LS=%b want HS&LS=000", $time, HS, LS);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    logic [8:0] want;
    RST = 1'b1; EN = 3'b111; DEAD = 8'd3; PWM = 3'b000;
    for (int i = 0; i < 3; i++) begin
      PWM = (i % 2 == 0) ? 3'b111 : 3'b000;
      tick();
      total++;
      if ({HS, LS, DT_ACTIVE} !== 9'b0) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, {HS, LS, DT_ACTIVE}, 9'b0);
      end
    end
    mon_en = 1'b1;
    // Release: every channel must pass a 3-cycle dead interval first.
    RST = 1'b0; PWM = 3'b101;
    for (int k = 1; k <= 4; k++) begin
      tick();
      want = (k < 4) ? {3'b000, 3'b000, 3'b111} : {3'b101, 3'b010, 3'b000};
      total++;
      if ({HS, LS, DT_ACTIVE} !== want) begin
        bad++;
        $display("FAIL reset_release k=%0d got=%b want=%b", k, {HS, LS, DT_ACTIVE}, want);
      end
    end
  endtask

  task automatic test_nominal();
    logic [8:0] want;
    DEAD = 8'd11; PWM = 3'b000;
    settle(20);
    total++;
    if ({HS, LS, DT_ACTIVE} !== {3'b000, 3'b111, 3'b000}) begin
      bad++;
      $display("FAIL nom_all_lo got=%b want=%b", {HS, LS, DT_ACTIVE}, {3'b000, 3'b111, 3'b000});
    end
    PWM = 3'b001;
    for (int k = 1; k <= 12; k++) begin
      tick();
      want = {2'b00, k == 12, 2'b11, 1'b0, 2'b00, k < 12};
      total++;
      if ({HS, LS, DT_ACTIVE} !== want) begin
        bad++;
        $display("FAIL nom_rise k=%0d got=%b want=%b", k, {HS, LS, DT_ACTIVE}, want);
      end
    end
    PWM = 3'b000;
    for (int k = 1; k <= 12; k++) begin
      tick();
      want = {2'b00, 1'b0, 2'b11, k == 12, 2'b00, k < 12};
      total++;
      if ({HS, LS, DT_ACTIVE} !== want) begin
        bad++;
        $display("FAIL nom_fall k=%0d got=%b want=%b", k, {HS, LS, DT_ACTIVE}, want);
      end
    end
  endtask

  task automatic test_min_dead();
    logic [8:0] want;
    DEAD = 8'd0; PWM = 3'b001;
    for (int k = 1; k <= 2; k++) begin
      tick();
      want = {2'b00, k == 2, 2'b11, 1'b0, 2'b00, k == 1};
      total++;
      if ({HS, LS, DT_ACTIVE} !== want) begin
        bad++;
        $display("FAIL min_rise k=%0d got=%b want=%b", k, {HS, LS, DT_ACTIVE}, want);
      end
    end
    PWM = 3'b000;
    for (int k = 1; k <= 2; k++) begin
      tick();
      want = {2'b00, 1'b0, 2'b11, k == 2, 2'b00, k == 1};
      total++;
      if ({HS, LS, DT_ACTIVE} !== want) begin
        bad++;
        $display("FAIL min_fall k=%0d got=%b want=%b", k, {HS, LS, DT_ACTIVE}, want);
      end
    end
  endtask

  task automatic test_short_pulse();
    DEAD = 8'd20; PWM = 3'b001;
    for (int k = 1; k <= 5; k++) begin
      tick();
      total++;
      if ({HS[0], LS[0], DT_ACTIVE[0]} !== 3'b001) begin
        bad++;
        $display("FAIL short_dt k=%0d got=%b want=%b", k, {HS[0], LS[0], DT_ACTIVE[0]}, 3'b001);
      end
    end
    PWM = 3'b000;
    tick();
    total++;
    if ({HS[0], LS[0], DT_ACTIVE[0]} !== 3'b010) begin
      bad++;
      $display("FAIL short_abort got=%b want=%b", {HS[0], LS[0], DT_ACTIVE[0]}, 3'b010);
    end
  endtask

  task automatic test_en_dead();
    logic [8:0] want;
    DEAD = 8'd11; PWM = 3'b001;
    settle(15);
    total++;
    if ({HS, LS, DT_ACTIVE} !== {3'b001, 3'b110, 3'b000}) begin
      bad++;
      $display("FAIL en_hi got=%b want=%b", {HS, LS, DT_ACTIVE}, {3'b001, 3'b110, 3'b000});
    end
    EN = 3'b110;
    tick();
    total++;
    if ({HS, LS, DT_ACTIVE} !== {3'b000, 3'b110, 3'b000}) begin
      bad++;
      $display("FAIL en_drop got=%b want=%b", {HS, LS, DT_ACTIVE}, {3'b000, 3'b110, 3'b000});
    end
    // Re-enable: dead interval of 11 loaded; DEAD change mid-interval ignored.
    EN = 3'b111;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) DEAD = 8'd4;
      want = {2'b00, k == 12, 2'b11, 1'b0, 2'b00, k < 12};
      total++;
      if ({HS, LS, DT_ACTIVE} !== want) begin
        bad++;
        $display("FAIL en_reentry k=%0d got=%b want=%b", k, {HS, LS, DT_ACTIVE}, want);
      end
    end
    PWM = 3'b000;
    for (int k = 1; k <= 5; k++) begin
      tick();
      want = {2'b00, 1'b0, 2'b11, k == 5, 2'b00, k < 5};
      total++;
      if ({HS, LS, DT_ACTIVE} !== want) begin
        bad++;
        $display("FAIL dead_change k=%0d got=%b want=%b", k, {HS, LS, DT_ACTIVE}, want);
      end
    end
  endtask

`ifdef DT_FAULT_EN
  task automatic test_fault();
    logic [9:0] want;
    DEAD = 8'd4; PWM = 3'b101;
    settle(10);
    FAULT = 1'b1;
    tick();
    total++;
    if ({FLT_LATCHED, HS, LS, DT_ACTIVE} !== 10'b1_000_000_000) begin
      bad++;
      $display("FAIL flt_set got=%b want=%b", {FLT_LATCHED, HS, LS, DT_ACTIVE}, 10'b1_000_000_000);
    end
    FLT_CLR = 1'b1;
    tick();
    total++;
    if ({FLT_LATCHED, HS, LS, DT_ACTIVE} !== 10'b1_000_000_000) begin
      bad++;
      $display("FAIL flt_clr_ign got=%b want=%b", {FLT_LATCHED, HS, LS, DT_ACTIVE},
               10'b1_000_000_000);
    end
    FAULT = 1'b0; FLT_CLR = 1'b0;
    tick();
    total++;
    if ({FLT_LATCHED, HS, LS, DT_ACTIVE} !== 10'b1_000_000_000) begin
      bad++;
      $display("FAIL flt_hold got=%b want=%b", {FLT_LATCHED, HS, LS, DT_ACTIVE}, 10'b1_000_000_000);
    end
    FLT_CLR = 1'b1;
    tick();
    FLT_CLR = 1'b0;
    total++;
    if ({FLT_LATCHED, HS, LS, DT_ACTIVE} !== 10'b0) begin
      bad++;
      $display("FAIL flt_clear got=%b want=%b", {FLT_LATCHED, HS, LS, DT_ACTIVE}, 10'b0);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      want = (k < 5) ? {1'b0, 3'b000, 3'b000, 3'b111} : {1'b0, 3'b101, 3'b010, 3'b000};
      total++;
      if ({FLT_LATCHED, HS, LS, DT_ACTIVE} !== want) begin
        bad++;
        $display("FAIL flt_resume k=%0d got=%b want=%b", k, {FLT_LATCHED, HS, LS, DT_ACTIVE},
                 want);
      end
    end
  endtask
`endif

  initial begin
    RST = 1'b1; EN = 3'b000; PWM = 3'b000; DEAD = 8'd0;
`ifdef DT_FAULT_EN
    FAULT = 1'b0; FLT_CLR = 1'b0;
`endif
    test_reset();
    test_nominal();
    test_min_dead();
    test_short_pulse();
    test_en_dead();
`ifdef DT_FAULT_EN
    test_fault();
`endif
    @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
